// File: rtl/mem_access_stage_p.sv
// ---------------------------------------------------------------------------
// mem_access_stage_p
//
// Memory-access (MA) pipeline stage for VCPU-32. It takes one instruction
// bundle per cycle from EX and performs at most one data-memory load or store
// per bundle over a req/ack interface. The completed bundle is then held in
// output registers for WB.
//
// Handshakes:
//   EX side  : inValid / outReady. outReady depends only on the state and on
//              inReady, so there is no combinational path from inValid.
//   WB side  : outValid / inReady. The held bundle stays stable while WB
//              stalls.
//   Memory   : outMemReq is held, with constant address, direction and data,
//              until a single-cycle inMemAck arrives or the wait counter
//              times out. A timeout completes the bundle with outTrap = 1.
//
// Parameters:
//   WORD_LENGTH    width of the instruction, PSTATE, operand and data words
//   ADR_LENGTH     memory address width, taken from the LSBs of inX
//   TIMEOUT_CYCLES maximum number of request cycles without an ack (>= 1)
//
// Optional feature (compile-time macro ALIGN_CHECK_EN):
//   When this macro is defined, a load or store whose inX[1:0] is not zero
//   issues no memory request. The bundle completes in one cycle with
//   outTrap = 1. When the macro is undefined, no alignment check is made.
//
// Ports:
//   inClk, inRst            clock, synchronous active-high reset
//   inValid, outReady       EX-side handshake
//   inIsLoad, inIsStore     decode flags (both set is treated as a load)
//   inPstate0/1, inInstr,
//   inA, inB, inX           incoming bundle (inB = store data, inX = address)
//   outMemReq, outMemWr,
//   outMemAdr, outMemData   memory request side
//   inMemAck, inMemData     memory completion and read data
//   outValid, inReady       WB-side handshake
//   outPstate0/1, outI,
//   outA, outB, outX        registered bundle (outX = load data for loads)
//   outTrap                 bundle finished with a memory timeout/alignment trap
// ---------------------------------------------------------------------------
module mem_access_stage_p #(
  parameter int WORD_LENGTH    = 32,
  parameter int ADR_LENGTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   inClk,
  input  logic                   inRst,

  input  logic                   inValid,
  output logic                   outReady,
  input  logic                   inIsLoad,
  input  logic                   inIsStore,
  input  logic [WORD_LENGTH-1:0] inPstate0,
  input  logic [WORD_LENGTH-1:0] inPstate1,
  input  logic [WORD_LENGTH-1:0] inInstr,
  input  logic [WORD_LENGTH-1:0] inA,
  input  logic [WORD_LENGTH-1:0] inB,
  input  logic [WORD_LENGTH-1:0] inX,

  output logic                   outMemReq,
  output logic                   outMemWr,
  output logic [ADR_LENGTH-1:0]  outMemAdr,
  output logic [WORD_LENGTH-1:0] outMemData,
  input  logic                   inMemAck,
  input  logic [WORD_LENGTH-1:0] inMemData,

  output logic                   outValid,
  input  logic                   inReady,
  output logic [WORD_LENGTH-1:0] outPstate0,
  output logic [WORD_LENGTH-1:0] outPstate1,
  output logic [WORD_LENGTH-1:0] outI,
  output logic [WORD_LENGTH-1:0] outA,
  output logic [WORD_LENGTH-1:0] outB,
  output logic [WORD_LENGTH-1:0] outX,
  output logic                   outTrap
);

  // The wait counter is sized to hold TIMEOUT_CYCLES. The timeout fires on
  // the last allowed request cycle, when the count is TIMEOUT_CYCLES-1, so
  // the request is held for exactly TIMEOUT_CYCLES cycles.
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no bundle held
    ST_MEM  = 2'd1,  // memory request outstanding
    ST_FULL = 2'd2   // completed bundle presented to WB
  } state_e;

  state_e                   state_q,   state_d;
  logic [CNT_W-1:0]         cnt_q,     cnt_d;
  logic                     wr_q,      wr_d;
  logic                     trap_q,    trap_d;
  logic [WORD_LENGTH-1:0]   pstate0_q, pstate0_d;
  logic [WORD_LENGTH-1:0]   pstate1_q, pstate1_d;
  logic [WORD_LENGTH-1:0]   instr_q,   instr_d;
  logic [WORD_LENGTH-1:0]   a_q,       a_d;
  logic [WORD_LENGTH-1:0]   b_q,       b_d;
  logic [WORD_LENGTH-1:0]   x_q,       x_d;

  logic ready;
  logic accept;
  logic is_mem;
  logic misaligned;
  logic start_mem;

  // The stage can take a new bundle when it is empty, or when the held
  // bundle leaves for WB this very cycle. Nothing is accepted while a memory
  // operation is outstanding.
  assign ready  = (state_q == ST_IDLE) || ((state_q == ST_FULL) && inReady);
  assign accept = inValid && ready;
  assign is_mem = inIsLoad || inIsStore;

`ifdef ALIGN_CHECK_EN
  assign misaligned = (inX[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned access never reaches memory. It completes at once with a trap.
  assign start_mem = is_mem && !misaligned;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    trap_d    = trap_q;
    pstate0_d = pstate0_q;
    pstate1_d = pstate1_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    x_d       = x_q;

    case (state_q)
      ST_MEM: begin
        if (inMemAck) begin
          // An ack wins over a timeout in the same cycle.
          state_d = ST_FULL;
          trap_d  = 1'b0;
          if (!wr_q) begin
            x_d = inMemData;
          end
        end else if (cnt_q == CNT_LAST) begin
          // The request is abandoned. outX keeps the captured address.
          state_d = ST_FULL;
          trap_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_IDLE, ST_FULL: begin
        if (accept) begin
          pstate0_d = inPstate0;
          pstate1_d = inPstate1;
          instr_d   = inInstr;
          a_d       = inA;
          b_d       = inB;
          x_d       = inX;
          trap_d    = 1'b0;
          if (start_mem) begin
            state_d = ST_MEM;
            cnt_d   = '0;
            // If both decode flags are set (an illegal combination), the
            // bundle is treated as a load.
            wr_d    = inIsStore && !inIsLoad;
          end else begin
            state_d = ST_FULL;
            trap_d  = is_mem && misaligned;
          end
        end else if ((state_q == ST_FULL) && inReady) begin
          state_d = ST_IDLE;
          trap_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge inClk) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the values from before the clock edge, whatever the
    // order of the statements.
    if (inRst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      trap_q    <= 1'b0;
      pstate0_q <= '0;
      pstate1_q <= '0;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      x_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      trap_q    <= trap_d;
      pstate0_q <= pstate0_d;
      pstate1_q <= pstate1_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      x_q       <= x_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all decoded from registers)
  // -------------------------------------------------------------------------
  assign outReady   = ready;
  assign outMemReq  = (state_q == ST_MEM);
  assign outMemWr   = (state_q == ST_MEM) && wr_q;
  assign outMemAdr  = x_q[ADR_LENGTH-1:0];
  assign outMemData = b_q;
  assign outValid   = (state_q == ST_FULL);
  assign outTrap    = trap_q;
  assign outPstate0 = pstate0_q;
  assign outPstate1 = pstate1_q;
  assign outI       = instr_q;
  assign outA       = a_q;
  assign outB       = b_q;
  assign outX       = x_q;

endmodule
